// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, paddle FSM and direction types,
// PS/2 scan codes and small decode helpers used by paddle_ctrl.
package pong_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SLOW,
        ST_FAST
    } paddle_state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    typedef enum logic {
        KB_IDLE,
        KB_BREAK
    } kb_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_KEY_W = 8'h1D;
    localparam logic [7:0] PS2_KEY_S = 8'h1B;
    localparam logic [7:0] PS2_KEY_O = 8'h44;
    localparam logic [7:0] PS2_KEY_L = 8'h4B;

    // Opposing buttons cancel out so a mashed pair never drifts the paddle.
    function automatic dir_t decode_dir(input logic up_btn, input logic down_btn);
        if (up_btn && !down_btn) return DIR_UP;
        if (down_btn && !up_btn) return DIR_DOWN;
        return DIR_NONE;
    endfunction

    // Held-key bit layout: {p1 down, p1 up, p0 down, p0 up}.
    function automatic logic [3:0] key_mask(input logic [7:0] code);
        case (code)
            PS2_KEY_W: return 4'b0001;
            PS2_KEY_S: return 4'b0010;
            PS2_KEY_O: return 4'b0100;
            PS2_KEY_L: return 4'b1000;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/paddle_debounce.sv
// One button input path: two-flop synchroniser followed by a stability
// counter; the debounced level flips after DEBOUNCE_CYCLES stable samples.
module paddle_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // NOTE: all state here is plain flops assigned with <=, so the
    // synchroniser chain shifts by exactly one stage per clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// N-player Pong paddle controller: debounced buttons drive a per-frame,
// clamped, hold-to-accelerate Y position. PADDLE_PS2_EN adds PS/2 keys.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int POS_W           = 10,
    parameter int SCREEN_H        = pong_pkg::SCREEN_H,
    parameter int PADDLE_H        = 80,
    parameter int STEP            = 4,
    parameter int ACCEL_FRAMES    = 16,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         pause,
    input  logic [NUM_PLAYERS-1:0]       up,
    input  logic [NUM_PLAYERS-1:0]       down,
`ifdef PADDLE_PS2_EN
    input  logic [7:0]                   ps2_key_data,
    input  logic                         ps2_key_pressed,
`endif
    output logic [NUM_PLAYERS*POS_W-1:0] paddle_y,
    output logic [NUM_PLAYERS-1:0]       at_top,
    output logic [NUM_PLAYERS-1:0]       at_bottom,
    output logic [NUM_PLAYERS-1:0]       moving
);

    localparam int Y_MAX_I = SCREEN_H - PADDLE_H;
    localparam int XW      = POS_W + 1;
    localparam int CNT_W   = $clog2(ACCEL_FRAMES + 1);

    localparam logic [POS_W-1:0] Y_MIDDLE   = POS_W'(Y_MAX_I / 2);
    localparam logic [XW-1:0]    Y_MAX_X    = XW'(Y_MAX_I);
    localparam logic [XW-1:0]    STEP_SLOW  = XW'(STEP);
    localparam logic [XW-1:0]    STEP_FAST  = XW'(2 * STEP);
    localparam logic [CNT_W-1:0] ACCEL_LAST = CNT_W'(ACCEL_FRAMES);

    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4) begin : g_bad_players
        $error("paddle_ctrl: NUM_PLAYERS must be 1..4");
    end
    if (PADDLE_H >= SCREEN_H || Y_MAX_I >= 2 ** POS_W) begin : g_bad_geom
        $error("paddle_ctrl: paddle does not fit screen or POS_W too narrow");
    end

    logic [NUM_PLAYERS-1:0] db_up;
    logic [NUM_PLAYERS-1:0] db_down;
    logic [NUM_PLAYERS-1:0] btn_up;
    logic [NUM_PLAYERS-1:0] btn_down;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_btn
        paddle_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
            .clock (clock),
            .reset (reset),
            .raw   (up[p]),
            .level (db_up[p])
        );
        paddle_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
            .clock (clock),
            .reset (reset),
            .raw   (down[p]),
            .level (db_down[p])
        );
    end

`ifdef PADDLE_PS2_EN
    kb_state_t  kb_state;
    logic [3:0] key_held;
    logic [3:0] key_up4;
    logic [3:0] key_down4;

    // Make codes set a held bit; the byte after 0xF0 is a release.
    always_ff @(posedge clock) begin
        if (reset) begin
            kb_state <= KB_IDLE;
            key_held <= '0;
        end else if (ps2_key_pressed) begin
            case (kb_state)
                KB_IDLE: begin
                    if (ps2_key_data == PS2_BREAK) kb_state <= KB_BREAK;
                    else                           key_held <= key_held | key_mask(ps2_key_data);
                end
                default: begin
                    key_held <= key_held & ~key_mask(ps2_key_data);
                    kb_state <= KB_IDLE;
                end
            endcase
        end
    end

    assign key_up4   = {2'b00, key_held[2], key_held[0]};
    assign key_down4 = {2'b00, key_held[3], key_held[1]};
    assign btn_up    = db_up   | key_up4[NUM_PLAYERS-1:0];
    assign btn_down  = db_down | key_down4[NUM_PLAYERS-1:0];
`else
    assign btn_up   = db_up;
    assign btn_down = db_down;
`endif

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        paddle_state_t    state;
        dir_t             last_dir;
        dir_t             dir;
        logic [CNT_W-1:0] frame_cnt;
        logic [POS_W-1:0] y;
        logic [XW-1:0]    y_ext;
        logic [XW-1:0]    step;
        logic [XW-1:0]    y_new;
        logic             top_q;
        logic             bottom_q;
        logic             moving_q;

        // NOTE: every always_comb output gets a default first, so no path
        // through the case can leave a latch behind.
        always_comb begin
            dir   = decode_dir(btn_up[p], btn_down[p]);
            step  = (state == ST_FAST && dir == last_dir) ? STEP_FAST : STEP_SLOW;
            y_ext = {1'b0, y};
            y_new = y_ext;
            case (dir)
                DIR_UP:   y_new = (y_ext < step) ? '0 : y_ext - step;
                DIR_DOWN: y_new = (y_ext + step > Y_MAX_X) ? Y_MAX_X : y_ext + step;
                default:  y_new = y_ext;
            endcase
        end

        // Limits still advance the FSM; only the position saturates.
        always_ff @(posedge clock) begin
            if (reset) begin
                state     <= ST_IDLE;
                last_dir  <= DIR_NONE;
                frame_cnt <= '0;
                y         <= Y_MIDDLE;
                top_q     <= 1'b0;
                bottom_q  <= 1'b0;
                moving_q  <= 1'b0;
            end else if (frame_tick) begin
                if (pause) begin
                    moving_q <= 1'b0;
                end else begin
                    y        <= y_new[POS_W-1:0];
                    moving_q <= (y_new != y_ext);
                    top_q    <= (y_new == '0);
                    bottom_q <= (y_new == Y_MAX_X);
                    last_dir <= dir;
                    if (dir == DIR_NONE) begin
                        state     <= ST_IDLE;
                        frame_cnt <= '0;
                    end else begin
                        case (state)
                            ST_IDLE: begin
                                state     <= ST_SLOW;
                                frame_cnt <= CNT_W'(1);
                            end
                            ST_SLOW: begin
                                if (dir != last_dir) begin
                                    frame_cnt <= CNT_W'(1);
                                end else begin
                                    frame_cnt <= frame_cnt + CNT_W'(1);
                                    if (frame_cnt + CNT_W'(1) == ACCEL_LAST) state <= ST_FAST;
                                end
                            end
                            default: begin
                                if (dir != last_dir) begin
                                    state     <= ST_SLOW;
                                    frame_cnt <= CNT_W'(1);
                                end
                            end
                        endcase
                    end
                end
            end
        end

        assign paddle_y[p*POS_W +: POS_W] = y;
        assign at_top[p]                  = top_q;
        assign at_bottom[p]               = bottom_q;
        assign moving[p]                  = moving_q;
    end

endmodule
